display_scan_controller: RTL and testbench

- Time-multiplexes one shared hex-to-7-segment decoder across NUM_DIGITS common-anode digits.
- Holds a double-buffered display value and walks the digits with a programmable dwell time.
- Inserts a blanking gap between digits to suppress ghosting and supports optional leading-zero suppression.
- Sits between the datapath that produces results and the board's segment and anode pins.

---
 rtl/display_scan_controller_pkg.sv | 8 +
 rtl/display_scan_controller_scan_timer.sv | 23 ++
 rtl/display_scan_controller.sv | 96 +++++++++
 tb/tb_display_scan_controller.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/display_scan_controller_pkg.sv
// display_scan_controller_pkg: shared state encoding, anode constant and counter sizing
package display_scan_controller_pkg;
  typedef enum logic [1:0] {ST_OFF, ST_BLANK, ST_SHOW} state_t;
  localparam logic [7:0] ANODE_OFF = 8'hFF;
  function automatic int cnt_width(input int dwell);
    return dwell > 1 ? $clog2(dwell) : 1;
  endfunction
endpackage

// File: rtl/display_scan_controller_scan_timer.sv
// scan_timer: per-slot cycle counter with blank-end, pre-end and slot-end strobes
module scan_timer
  import display_scan_controller_pkg::*;
#(
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  output logic o_blank_done,
  output logic o_pre_done,
  output logic o_slot_done
);
  localparam int CW = cnt_width(DWELL_CYCLES);
  logic [CW-1:0] r_cnt;
  assign o_blank_done = r_cnt == CW'(BLANK_CYCLES - 1);
  assign o_pre_done   = r_cnt == CW'(DWELL_CYCLES - 2);
  assign o_slot_done  = r_cnt == CW'(DWELL_CYCLES - 1);
  always_ff @(posedge clk)
    if (rst || !i_run || o_slot_done) r_cnt <= '0;
    else r_cnt <= r_cnt + 1'b1;
endmodule

// File: rtl/display_scan_controller.sv
// display_scan_controller: multiplexes a shared hex decoder across common-anode digits
module display_scan_controller
  import display_scan_controller_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_blank,
  output logic [3:0]              digit_code,
  output logic                    seg_blank,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_tick
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  state_t r_state, w_nstate;
  logic [IW-1:0] r_idx, w_nidx;
  logic [4*NUM_DIGITS-1:0] r_shadow, r_active;
  logic w_run, w_blank_done, w_pre_done, w_slot_done;
  logic w_boundary, w_acc, w_copy, w_hide, w_z;
  logic [NUM_DIGITS-1:0] w_lz;
  logic [3:0] w_nib [NUM_DIGITS];

  assign w_run = enable && r_state != ST_OFF;

  scan_timer #(
    .DWELL_CYCLES(DWELL_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .i_run       (w_run),
    .o_blank_done(w_blank_done),
    .o_pre_done  (w_pre_done),
    .o_slot_done (w_slot_done)
  );

  assign w_nstate = !enable ? ST_OFF :
                    r_state == ST_OFF ? ST_BLANK :
                    r_state == ST_BLANK ? (w_blank_done ? ST_BLANK == ST_BLANK ? ST_SHOW : ST_SHOW : ST_BLANK) :
                    (w_slot_done ? ST_BLANK : ST_SHOW);
  assign w_nidx = !enable ? '0 :
                  r_state == ST_OFF ? LAST_IDX :
                  (r_state == ST_SHOW && w_slot_done) ? (r_idx == '0 ? LAST_IDX : r_idx - 1'b1) :
                  r_idx;
  // the frame boundary is the end of digit 0's slot; while dark any pending value lands at once
  assign w_boundary = r_state == ST_OFF || (r_state == ST_SHOW && w_slot_done && r_idx == '0);
  assign w_acc  = load_valid && load_ready;
  assign w_copy = !load_ready && w_boundary;
  assign w_hide = lz_blank && w_lz[w_nidx];

  always_comb begin
    w_z  = 1'b1;
    w_lz = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      w_z     = w_z && r_active[4*i +: 4] == 4'h0 && !dp_in[i];
      w_lz[i] = w_z;
    end
    for (int i = 0; i < NUM_DIGITS; i++) w_nib[i] = r_active[4*i +: 4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_OFF;
      r_idx      <= '0;
      r_shadow   <= '0;
      r_active   <= '0;
      load_ready <= 1'b1;
      digit_sel  <= ANODE_OFF[NUM_DIGITS-1:0];
      digit_code <= 4'h0;
      seg_blank  <= 1'b1;
      dp_out     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      r_state    <= w_nstate;
      r_idx      <= w_nidx;
      digit_sel  <= w_nstate == ST_SHOW ? ~(NUM_DIGITS'(1) << w_nidx) : ANODE_OFF[NUM_DIGITS-1:0];
      digit_code <= w_nstate == ST_SHOW ? w_nib[w_nidx] : 4'h0;
      seg_blank  <= w_nstate != ST_SHOW || w_hide;
      dp_out     <= w_nstate == ST_SHOW && dp_in[w_nidx] && !w_hide;
      frame_tick <= w_run && r_idx == '0 && w_pre_done;
      if (w_copy) r_active <= r_shadow;
      if (w_acc) r_shadow <= value_in;
      load_ready <= w_acc ? 1'b0 : (w_copy ? 1'b1 : load_ready);
    end
  end
endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller: table, directed and randomized checks against a slot-arithmetic model
module tb_display_scan_controller;
  localparam int N = 4, D = 8, B = 2, FRAME = N * D;
  logic clk = 1'b0, rst = 1'b0, enable = 1'b0, load_valid = 1'b0, lz_blank = 1'b0;
  logic [15:0] value_in = 16'h0;
  logic [3:0] dp_in = 4'h0;
  logic load_ready, seg_blank, dp_out, frame_tick;
  logic [3:0] digit_code, digit_sel;
  int total = 0, bad = 0;
  int m_t = -1;
  logic [15:0] m_act = 16'h0, m_sh = 16'h0;
  logic m_pend = 1'b0;

  always #5 clk = ~clk;

  display_scan_controller #(.NUM_DIGITS(N), .DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst(rst), .enable(enable), .load_valid(load_valid), .load_ready(load_ready),
    .value_in(value_in), .dp_in(dp_in), .lz_blank(lz_blank), .digit_code(digit_code),
    .seg_blank(seg_blank), .dp_out(dp_out), .digit_sel(digit_sel), .frame_tick(frame_tick)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Model: time since enable splits into D-cycle slots; slot s shows digit N-1-(s mod N) after B blank cycles.
  task automatic step();
    logic acc, show, hide;
    int slot, pos, dig;
    logic [11:0] e, o;
    @(posedge clk);
    if (rst) begin
      m_t = -1; m_act = 16'h0; m_sh = 16'h0; m_pend = 1'b0;
    end else begin
      acc = load_valid && !m_pend;
      if (m_pend && (m_t < 0 || m_t % FRAME == FRAME - 1)) begin
        m_act = m_sh; m_pend = 1'b0;
      end
      if (acc) begin
        m_sh = value_in; m_pend = 1'b1;
      end
      m_t = enable ? m_t + 1 : -1;
    end
    if (m_t < 0) e = {4'hF, 4'h0, 1'b1, 1'b0, 1'b0, !m_pend};
    else begin
      slot = m_t / D; pos = m_t % D; dig = N - 1 - slot % N; show = pos >= B;
      hide = lz_blank && dig != 0;
      for (int k = dig; k < N; k++) if (m_act[4*k +: 4] != 4'h0 || dp_in[k]) hide = 1'b0;
      e = {show ? ~(4'b1 << dig) : 4'hF, show ? m_act[4*dig +: 4] : 4'h0, !show || hide,
           show && dp_in[dig] && !hide, show && dig == 0 && pos == D - 1, !m_pend};
    end
    #1;
    o = {digit_sel, digit_code, seg_blank, dp_out, frame_tick, load_ready};
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL model t=%0d: got %h, expected %h", m_t, o, e);
    end
  endtask

  task automatic wait_sel(input logic [3:0] t);
    int n = 0;
    while (digit_sel !== t && n < 100) begin step(); n++; end
    chk("wait_sel", {12'h0, digit_sel}, {12'h0, t});
  endtask

  typedef struct {
    logic rst, en;
    logic [3:0] sel, code;
    logic blank, dpo, rdy;
  } vec_t;

  initial begin
    vec_t tbl[12];
    logic [3:0] sels[4];
    int k0, k1, nt, n;
    logic got;
    sels = '{4'h7, 4'hB, 4'hD, 4'hE};
    tbl[0]  = '{1'b1, 1'b0, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b1, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1};
    for (int i = 3; i < 9; i++) tbl[i] = '{1'b0, 1'b1, 4'h7, 4'h0, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 4'hB, 4'h0, 1'b0, 1'b0, 1'b1};
    dp_in = 4'b1000;
    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst; enable = tbl[i].en;
      step();
      chk($sformatf("tbl%0d", i), {5'h0, digit_sel, digit_code, seg_blank, dp_out, load_ready},
          {5'h0, tbl[i].sel, tbl[i].code, tbl[i].blank, tbl[i].dpo, tbl[i].rdy});
    end
    dp_in = 4'h0;
    k0 = -1; k1 = -1; nt = 0;
    for (int k = 0; k < 70; k++) begin
      step();
      if (frame_tick) begin
        nt++;
        if (k0 < 0) k0 = k; else if (k1 < 0) k1 = k;
      end
    end
    chk("tick_count", 16'(nt), 16'd2);
    chk("tick_first", 16'(k0), 16'd20);
    chk("tick_period", 16'(k1 - k0), 16'd32);
    value_in = 16'h12AF; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    chk("load_ready_drop", {15'h0, load_ready}, 16'h0);
    wait_sel(4'hE);
    chk("old_frame_code", {12'h0, digit_code}, 16'h0);
    chk("ready_held", {15'h0, load_ready}, 16'h0);
    wait_sel(4'h7);
    chk("ready_back", {15'h0, load_ready}, 16'h1);
    chk("new_d3", {12'h0, digit_code}, 16'h1);
    wait_sel(4'hB); chk("new_d2", {12'h0, digit_code}, 16'h2);
    wait_sel(4'hD); chk("new_d1", {12'h0, digit_code}, 16'hA);
    wait_sel(4'hE); chk("new_d0", {12'h0, digit_code}, 16'hF);
    lz_blank = 1'b1; value_in = 16'h0030; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    wait_sel(4'h7); chk("lz_d3", {15'h0, seg_blank}, 16'h1);
    wait_sel(4'hB); chk("lz_d2", {15'h0, seg_blank}, 16'h1);
    wait_sel(4'hD); chk("lz_d1", {11'h0, seg_blank, digit_code}, 16'h3);
    wait_sel(4'hE); chk("lz_d0", {11'h0, seg_blank, digit_code}, 16'h0);
    dp_in = 4'b0100;
    wait_sel(4'h7); chk("lzdp_d3", {14'h0, seg_blank, dp_out}, 16'h2);
    wait_sel(4'hB); chk("lzdp_d2", {14'h0, seg_blank, dp_out}, 16'h1);
    lz_blank = 1'b0; dp_in = 4'h0;
    step();
    enable = 1'b0;
    step();
    chk("off_sel", {11'h0, digit_sel, seg_blank}, 16'h1F);
    step(); step();
    enable = 1'b1;
    step(); chk("reen_blank0", {12'h0, digit_sel}, 16'hF);
    step(); chk("reen_blank1", {12'h0, digit_sel}, 16'hF);
    step(); chk("reen_d3", {12'h0, digit_sel}, 16'h7);
    value_in = 16'h1111; load_valid = 1'b1;
    step();
    value_in = 16'h2222;
    chk("bb_hold", {15'h0, load_ready}, 16'h0);
    n = 0; got = 1'b0;
    while (!got && n < 100) begin got = load_ready; step(); n++; end
    load_valid = 1'b0;
    chk("bb_accept", {15'h0, got}, 16'h1);
    chk("bb_wait", 16'(n), 16'd30);
    chk("bb_pending", {15'h0, load_ready}, 16'h0);
    for (int f = 0; f < 2; f++)
      for (int j = 0; j < 4; j++) begin
        wait_sel(sels[j]);
        chk($sformatf("bb_f%0d_s%0d", f, j), {12'h0, digit_code}, f == 0 ? 16'h1 : 16'h2);
      end
    value_in = 16'h5555; load_valid = 1'b1;
    step();
    load_valid = 1'b0; rst = 1'b1;
    step();
    chk("rst_outputs", {4'h0, digit_sel, digit_code, seg_blank, dp_out, frame_tick, load_ready}, 16'h0F09);
    rst = 1'b0;
    step();
    wait_sel(4'h7);
    chk("rst_discard", {12'h0, digit_code}, 16'h0);
    lz_blank = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 149) == 0) enable = !enable;
      rst = $urandom_range(0, 799) == 0;
      load_valid = $urandom_range(0, 5) == 0;
      for (int k = 0; k < N; k++) value_in[4*k +: 4] = $urandom_range(0, 2) == 0 ? 4'($urandom) : 4'h0;
      dp_in = $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 39) == 0) lz_blank = !lz_blank;
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
